// File: rtl/fp16_multiplier.sv
// fp16_multiplier: IEEE-754 half-precision (1/5/10, bias 15) multiplier.
// Multi-cycle FSM with stb/ack handshakes on both operands and the result:
// a is always accepted first, then b. Rounding is round-to-nearest-even,
// and denormals are fully supported through gradual underflow.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-low reset
//   input_a/_stb  operand a and its valid; input_a_ack = ready for a
//   input_b/_stb  operand b and its valid; input_b_ack = ready for b
//   output_z/_stb product (registered) and its valid; output_z_ack = consumer ready
//
// Build option: define FP16_MULTIPLIER_FTZ_EN to treat denormal inputs as zero
// and flush denormal results to signed zero.
module fp16_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [15:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [15:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL_CASES, NORMALISE_A, NORMALISE_B,
        MULTIPLY_0, MULTIPLY_1, NORMALISE_1, NORMALISE_2, ROUND, PACK, PUT_Z
    } state_t;

    state_t state, state_next;

    logic [15:0]       a, b;
    logic [10:0]       a_m, b_m, z_m;
    logic signed [6:0] a_e, b_e, z_e;
    logic              a_s, b_s, z_s;
    logic              guard, round_bit, sticky;
    logic [21:0]       product;

    // Operand classification, valid while in SPECIAL_CASES (unpacked fields).
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_den, b_den, special;
    logic [15:0] z_special;

    always_comb begin
        a_nan = (a_e == 7'sd16) && (a_m[9:0] != 10'd0);
        b_nan = (b_e == 7'sd16) && (b_m[9:0] != 10'd0);
        a_inf = (a_e == 7'sd16) && (a_m[9:0] == 10'd0);
        b_inf = (b_e == 7'sd16) && (b_m[9:0] == 10'd0);
        a_den = (a_e == -7'sd15);
        b_den = (b_e == -7'sd15);
`ifdef FP16_MULTIPLIER_FTZ_EN
        a_zero = a_den;
        b_zero = b_den;
`else
        a_zero = a_den && (a_m[9:0] == 10'd0);
        b_zero = b_den && (b_m[9:0] == 10'd0);
`endif
        special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

        if (a_nan || b_nan)
            z_special = 16'hFE00;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            z_special = 16'hFE00;
        else if (a_inf || b_inf)
            z_special = {a_s ^ b_s, 5'h1F, 10'h000};
        else
            z_special = {a_s ^ b_s, 15'h0000};
    end

    // Final packing of the rounded result.
    logic signed [6:0] z_eb;
    logic [4:0]        z_exp;
    logic [15:0]       z_packed;

    always_comb begin
        z_eb  = z_e + 7'sd15;
        z_exp = z_eb[4:0];
        // Exponent -14 without the hidden bit is a denormal (or zero).
        if (z_e == -7'sd14 && !z_m[10])
            z_exp = 5'd0;
        z_packed = {z_s, z_exp, z_m[9:0]};
`ifdef FP16_MULTIPLIER_FTZ_EN
        if (z_exp == 5'd0 && z_m[9:0] != 10'd0)
            z_packed = {z_s, 15'h0000};
`endif
        if (z_e > 7'sd15)
            z_packed = {z_s, 5'h1F, 10'h000};
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= GET_A;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            GET_A:         if (input_a_ack && input_a_stb) state_next = GET_B;
            GET_B:         if (input_b_ack && input_b_stb) state_next = UNPACK;
            UNPACK:        state_next = SPECIAL_CASES;
            SPECIAL_CASES: state_next = special ? PUT_Z : NORMALISE_A;
            NORMALISE_A:   if (a_m[10]) state_next = NORMALISE_B;
            NORMALISE_B:   if (b_m[10]) state_next = MULTIPLY_0;
            MULTIPLY_0:    state_next = MULTIPLY_1;
            MULTIPLY_1:    state_next = NORMALISE_1;
            NORMALISE_1:   if (z_m[10] || z_e <= -7'sd14) state_next = NORMALISE_2;
            NORMALISE_2:   if (z_e >= -7'sd14) state_next = ROUND;
            ROUND:         state_next = PACK;
            PACK:          state_next = PUT_Z;
            PUT_Z:         if (output_z_stb && output_z_ack) state_next = GET_A;
            default:       state_next = GET_A;
        endcase
    end

    // Handshake outputs and datapath. Only the visible outputs need reset;
    // datapath registers are always written before they are read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= 16'h0000;
        end else begin
            case (state)
                GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a           <= input_a;
                        input_a_ack <= 1'b0;
                    end
                end
                GET_B: begin
                    input_b_ack <= 1'b1;
                    if (input_b_ack && input_b_stb) begin
                        b           <= input_b;
                        input_b_ack <= 1'b0;
                    end
                end
                UNPACK: begin
                    a_m <= {1'b0, a[9:0]};
                    b_m <= {1'b0, b[9:0]};
                    a_e <= 7'({2'b00, a[14:10]}) - 7'sd15;
                    b_e <= 7'({2'b00, b[14:10]}) - 7'sd15;
                    a_s <= a[15];
                    b_s <= b[15];
                end
                SPECIAL_CASES: begin
                    if (special) begin
                        output_z     <= z_special;
                        output_z_stb <= 1'b1;
                    end else begin
                        // Denormals carry exponent -14 with no hidden bit.
                        if (a_den) a_e <= -7'sd14;
                        else       a_m[10] <= 1'b1;
                        if (b_den) b_e <= -7'sd14;
                        else       b_m[10] <= 1'b1;
                    end
                end
                NORMALISE_A: if (!a_m[10]) begin
                    a_m <= a_m << 1;
                    a_e <= a_e - 7'sd1;
                end
                NORMALISE_B: if (!b_m[10]) begin
                    b_m <= b_m << 1;
                    b_e <= b_e - 7'sd1;
                end
                MULTIPLY_0: begin
                    z_s     <= a_s ^ b_s;
                    // +1 because z_m takes the product's top 11 bits (2.20 -> 1.10).
                    z_e     <= a_e + b_e + 7'sd1;
                    product <= 22'(a_m) * 22'(b_m);
                end
                MULTIPLY_1: begin
                    z_m       <= product[21:11];
                    guard     <= product[10];
                    round_bit <= product[9];
                    sticky    <= |product[8:0];
                end
                NORMALISE_1: if (!z_m[10] && z_e > -7'sd14) begin
                    z_e       <= z_e - 7'sd1;
                    z_m       <= {z_m[9:0], guard};
                    guard     <= round_bit;
                    round_bit <= 1'b0;
                end
                NORMALISE_2: if (z_e < -7'sd14) begin
                    z_e       <= z_e + 7'sd1;
                    z_m       <= z_m >> 1;
                    guard     <= z_m[0];
                    round_bit <= guard;
                    sticky    <= sticky | round_bit;
                end
                ROUND: if (guard && (round_bit || sticky || z_m[0])) begin
                    z_m <= z_m + 11'd1;
                    if (z_m == 11'h7FF) begin
                        z_m <= 11'h400;
                        z_e <= z_e + 7'sd1;
                    end
                end
                PACK: begin
                    output_z     <= z_packed;
                    output_z_stb <= 1'b1;
                end
                PUT_Z: if (output_z_stb && output_z_ack)
                    output_z_stb <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
